io_turnaround_ctrl: RTL



---
 rtl/io_turnaround_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/io_turnaround_ctrl.sv
// Half-duplex turnaround controller for one shared pin: shifts a word out LSB-first,
// releases the pin for a fixed gap, then shifts a reply word in and offers it on rx.
module io_turnaround_ctrl #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             ASYNCRESET,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [WIDTH-1:0] rx_data,
   inout  wire              IO,
   output logic             O,
   output logic             oe
);

   localparam int MAX_CNT = (WIDTH > TURN_CYCLES) ? WIDTH : TURN_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(TURN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_TURN,
      S_SAMPLE,
      S_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             oe_q, oe_d;
   logic             o_q, o_d;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through the case leaves one unassigned (no latches).
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               tx_shift_d = tx_data;
               cnt_d      = '0;
               state_d    = S_DRIVE;
            end
         end
         S_DRIVE: begin
            tx_shift_d = tx_shift_q >> 1;
            if (cnt_q == LAST_BIT) begin
               cnt_d   = '0;
               state_d = S_TURN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_TURN: begin
            if (cnt_q == LAST_TURN) begin
               cnt_d   = '0;
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            // Bits enter at the MSB end so the first sample ends up in bit 0.
            for (int i = 0; i < WIDTH - 1; i++) begin
               rx_shift_d[i] = rx_shift_q[i+1];
            end
            rx_shift_d[WIDTH-1] = IO;
            if (cnt_q == LAST_BIT) begin
               rx_data_d  = rx_shift_d;
               rx_valid_d = 1'b1;
               cnt_d      = '0;
               state_d    = S_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (rx_ready) begin
               rx_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Pin controls are registered from the next state so oe drops on the edge entering TURN.
      oe_d = (state_d == S_DRIVE);
      o_d  = oe_d ? tx_shift_d[0] : 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         oe_q       <= 1'b0;
         o_q        <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         oe_q       <= oe_d;
         o_q        <= o_d;
      end
   end

   assign tx_ready = (state_q == S_IDLE) && !ASYNCRESET;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign oe       = oe_q;
   assign O        = o_q;
   assign IO       = oe_q ? o_q : 1'bz;

endmodule
